// File: rtl/imem_responder.sv
// imem_responder: PC-indexed instruction memory, valid/ready request in, in-order tagged responses out via a small FIFO.
// Ports: clk, rst (sync active-low); req_valid_i/req_ready_o/req_pc_i request channel;
// rsp_valid_o/rsp_ready_i/rsp_pc_o/rsp_insn_o/rsp_err_o response channel; load_en_i/load_addr_i/load_data_i array fill.
// Optional IMEM_ADDR_CHECK_EN: fault misaligned/out-of-range requests (NOP + err) and drop such loads.
module imem_responder #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 32,
  parameter logic [AWIDTH-1:0] BASEADDR = 'h01000000,
  parameter int MEM_WORDS = 4096,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [AWIDTH-1:0] req_pc_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [AWIDTH-1:0] rsp_pc_o,
  output logic [DWIDTH-1:0] rsp_insn_o,
  output logic              rsp_err_o,
  input  logic              load_en_i,
  input  logic [AWIDTH-1:0] load_addr_i,
  input  logic [DWIDTH-1:0] load_data_i
);
  localparam int IW = $clog2(MEM_WORDS);
  localparam int CW = $clog2(FIFO_DEPTH);
  function automatic logic [IW-1:0] idx(input logic [AWIDTH-1:0] a);
    return IW'((a - BASEADDR) >> 2);
  endfunction
  logic [DWIDTH-1:0] mem [MEM_WORDS];
  logic req_fault, load_fault;
`ifdef IMEM_ADDR_CHECK_EN
  function automatic logic bad(input logic [AWIDTH-1:0] a);
    return a[1:0] != 2'b00 || a < BASEADDR || ((a - BASEADDR) >> (IW + 2)) != '0;
  endfunction
  assign req_fault = bad(req_pc_i);
  assign load_fault = bad(load_addr_i);
`else
  assign req_fault = 1'b0;
  assign load_fault = 1'b0;
`endif
  logic              rdy_en, rd_valid, rd_err;
  logic [AWIDTH-1:0] rd_pc;
  logic [DWIDTH-1:0] rd_insn;
  logic [AWIDTH-1:0] f_pc   [FIFO_DEPTH];
  logic [DWIDTH-1:0] f_insn [FIFO_DEPTH];
  logic              f_err  [FIFO_DEPTH];
  logic [CW-1:0]     wptr, rptr;
  logic [CW:0]       count;
  logic              req_fire, pop;
  // rdy_en keeps the request channel closed during reset and opens it one cycle after release
  assign req_ready_o = rdy_en && (int'(count) + int'(rd_valid) < FIFO_DEPTH);
  assign req_fire = req_valid_i && req_ready_o;
  assign rsp_valid_o = count != '0;
  assign pop = rsp_valid_o && rsp_ready_i;
  assign rsp_pc_o = f_pc[rptr];
  assign rsp_insn_o = f_insn[rptr];
  assign rsp_err_o = f_err[rptr];
  // array is never reset; a load colliding with a read lets the read see the old word
  always_ff @(posedge clk)
    if (load_en_i && !load_fault) mem[idx(load_addr_i)] <= load_data_i;
  always_ff @(posedge clk) begin
    if (!rst) begin
      rdy_en <= 1'b0;
      rd_valid <= 1'b0;
      rd_pc <= '0;
      rd_insn <= '0;
      rd_err <= 1'b0;
      wptr <= '0;
      rptr <= '0;
      count <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        f_pc[i] <= '0;
        f_insn[i] <= '0;
        f_err[i] <= 1'b0;
      end
    end else begin
      rdy_en <= 1'b1;
      rd_valid <= req_fire;
      if (req_fire) begin
        rd_pc <= req_pc_i;
        rd_insn <= req_fault ? DWIDTH'(32'h00000013) : mem[idx(req_pc_i)];
        rd_err <= req_fault;
      end
      if (rd_valid) begin
        f_pc[wptr] <= rd_pc;
        f_insn[wptr] <= rd_insn;
        f_err[wptr] <= rd_err;
        wptr <= wptr + 1'b1;
      end
      if (pop) rptr <= rptr + 1'b1;
      count <= count + (CW+1)'(rd_valid) - (CW+1)'(pop);
    end
  end
endmodule

// File: doc/imem_responder.md
# imem_responder

Instruction-memory responder that answers the fetch stage's program-counter requests with 32-bit instruction words. The fetch stage issues a PC on a valid/ready request channel. This block looks the address up in an internal word-addressed array and returns the instruction, tagged with its PC, on a valid/ready response channel. A small response FIFO decouples the two channels. A side load port lets the bench or boot logic fill the array.

## Interface
- DWIDTH, 32, instruction/data word width
- AWIDTH, 32, address width
- BASEADDR, 32'h01000000, byte address of array word 0
- MEM_WORDS, 4096, array depth in words (power of two)
- FIFO_DEPTH, 4, response FIFO entries (power of two, ≥2)

- clk  in  1  clock; all logic on posedge
- rst  in  1  synchronous, active-low reset (asserted when 0)
- req_valid_i  in  1  fetch request valid
- req_ready_o  out  1  responder can accept a request
- req_pc_i  in  AWIDTH  requested byte address
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  consumer accepts response
- rsp_pc_o  out  AWIDTH  PC of the returned instruction
- rsp_insn_o  out  DWIDTH  instruction word
- rsp_err_o  out  1  address fault on this response
- load_en_i  in  1  write one word into the array
- load_addr_i  in  AWIDTH  load byte address (same mapping as requests)
- load_data_i  in  DWIDTH  load data

## Operation
- Address mapping: idx = (pc − BASEADDR) >> 2, truncated to log2(MEM_WORDS) bits.
- Request accept: valid and ready both high at a posedge.
- Accepted request is read from the array into a one-stage read register (in-flight flag set). On the next posedge, {pc, insn, err} is pushed into the FIFO.
- Response channel shows the FIFO head. An entry pops on a posedge where rsp_valid_o and rsp_ready_i are both high.
- req_ready_o = (fifo_count + inflight) < FIFO_DEPTH. It is computed combinationally from registered state and must not depend on rsp_ready_i.
- Push and pop in the same cycle leave the count unchanged. A pop frees a slot that becomes visible to req_ready_o in the following cycle.
- Responses are returned strictly in request order.
- Load port:
  - Writes array[idx(load_addr_i)] at posedge when load_en_i is high.
  - No handshake; loads are always accepted.
  - A load and a read of the same word in the same cycle: the read returns the old data.
  - Misaligned or out-of-range loads are dropped when IMEM_ADDR_CHECK_EN is defined.
- Array contents are not cleared by reset.
- Reset (rst==0 at posedge):
  - FIFO emptied; in-flight read discarded.
  - Outputs: rsp_valid_o=0, rsp_pc_o=0, rsp_insn_o=0, rsp_err_o=0, req_ready_o=0.
  - req_ready_o rises in the first cycle after rst returns high.
  - Reset mid-transfer drops all pending responses; nothing is replayed.

## Timing
- Latency: request accepted at edge N → response visible on rsp_valid_o after edge N+1, assuming the FIFO is empty.
- Throughput: one request per cycle sustained while rsp_ready_i stays high.
- Full: with rsp_ready_i held low, exactly FIFO_DEPTH requests are accepted, then req_ready_o=0.
- Response outputs hold stable while rsp_valid_o=1 and rsp_ready_i=0.
- Empty FIFO: rsp_valid_o=0; rsp_pc_o/rsp_insn_o hold their last value (don't-care).

## Configuration
- IMEM_ADDR_CHECK_EN defined:
  - A request is faulted when pc[1:0]≠0, pc<BASEADDR, or pc ≥ BASEADDR+4·MEM_WORDS.
  - A faulted request returns rsp_insn_o=32'h00000013 (NOP) with rsp_err_o=1 and the original PC.
  - Faulted loads are dropped.
- Not defined:
  - rsp_err_o is tied 0.
  - Addresses wrap modulo the array size and the low 2 bits are ignored.

## Test plan
- Reset: hold rst=0 three cycles with req_valid_i=1 → rsp_valid_o=0 and req_ready_o=0 throughout; req_ready_o=1 one cycle after release.
- Load, then stream:
  - Load 32'h00500093 at 0x01000000 and 32'h00a00113 at 0x01000004.
  - Request both on back-to-back cycles with rsp_ready_i=1.
  - Expect responses on consecutive cycles: {0x01000000, 0x00500093}, then {0x01000004, 0x00a00113}; err=0.
- Backpressure: rsp_ready_i=0, request 0x01000000..0x01000014 → exactly 4 accepted, then req_ready_o=0. Release → 4 in-order responses; the 5th request is accepted one cycle after the first pop.
- Same-word read/load collision: word 0 holds 0x11111111; load 0x22222222 to word 0 in the same cycle as a request to 0x01000000 → response 0x11111111; the next request returns 0x22222222.
- Faults, with IMEM_ADDR_CHECK_EN defined:
  - Request 0x01000002 and 0x00FFFFFC → both return insn 0x00000013, err=1, original PC.
  - Without the macro, 0x01000002 returns word 0 with err=0.
- Reset mid-operation: 3 responses queued, rst=0 one cycle → FIFO empty, rsp_valid_o=0, and the array still returns the loaded data afterwards.
